// File: rtl/mac_result_drain.sv
// Result drain for the 4-MAC array: assembles per-MAC results into tiles, queues whole tiles,
// and streams them out one rescaled/saturated lane per beat.
module mac_result_drain #(
  parameter int ACC_W = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 0,
  parameter int RELU  = 0,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [ACC_W-1:0]         acc_in_0,
  input  logic [ACC_W-1:0]         acc_in_1,
  input  logic [ACC_W-1:0]         acc_in_2,
  input  logic [ACC_W-1:0]         acc_in_3,
  input  logic [3:0]               valid_in,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_lane,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     dup_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  logic [ACC_W-1:0] slot [4];
  logic [ACC_W-1:0] cap  [4];
  logic [ACC_W-1:0] mem  [DEPTH][4];
  logic [3:0]       pending;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [1:0]       lane;

  logic tile_done;
  logic full;
  logic accept;
  logic pop;
  logic push;
  logic drop;

  // Same-cycle captures take priority over the held slot value when a tile completes.
  always_comb begin
    cap[0] = valid_in[0] ? acc_in_0 : slot[0];
    cap[1] = valid_in[1] ? acc_in_1 : slot[1];
    cap[2] = valid_in[2] ? acc_in_2 : slot[2];
    cap[3] = valid_in[3] ? acc_in_3 : slot[3];
  end

  // Handshake: a beat transfers on any edge where out_valid and out_ready are both high;
  // out_valid only falls through a pop, flush or rst, and the beat is held while stalled.
  assign tile_done = ((pending | valid_in) == 4'b1111);
  assign full      = (count == CW'(DEPTH));
  assign accept    = out_valid && out_ready;
  assign pop       = accept && (lane == 2'd3);
  assign push      = tile_done && (!full || pop);
  assign drop      = tile_done && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) slot[i] <= '0;
      for (int d = 0; d < DEPTH; d++)
        for (int i = 0; i < 4; i++) mem[d][i] <= '0;
      pending  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      lane     <= '0;
      overflow <= 1'b0;
      dup_err  <= 1'b0;
    end else if (flush) begin
      pending <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      lane    <= '0;
    end else begin
      for (int i = 0; i < 4; i++) slot[i] <= cap[i];
      if ((valid_in & pending) != 4'b0000) dup_err <= 1'b1;
      pending <= tile_done ? 4'b0000 : (pending | valid_in);
      if (push) begin
        for (int i = 0; i < 4; i++) mem[wr_ptr][i] <= cap[i];
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (drop) overflow <= 1'b1;
      if (accept) lane <= lane + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  logic signed [ACC_W-1:0] lane_acc;
  logic signed [ACC_W-1:0] v;

  // Rescale: arithmetic shift (floor), optional ReLU, then clamp into the signed OUT_W range.
  always_comb begin
    lane_acc = mem[rd_ptr][lane];
    v        = lane_acc >>> SHIFT;
    if (RELU != 0 && v < 0) v = '0;
    out_data = '0;
    if (out_valid) begin
      if (v > SAT_HI)      out_data = SAT_HI[OUT_W-1:0];
      else if (v < SAT_LO) out_data = SAT_LO[OUT_W-1:0];
      else                 out_data = v[OUT_W-1:0];
    end
  end

  assign out_valid  = (count != '0);
  assign out_lane   = lane;
  assign out_last   = (lane == 2'd3);
  assign fifo_count = count;

endmodule
